// File: rtl/regfile_mp.sv
// Multi-port register file for the RISC-16 datapath: two write ports
// (A = ALU/PC, B = memory), NUM_RD combinational read ports with optional
// same-cycle bypass, and a per-register load-pending scoreboard.

// One read port: selects the addressed register and applies write bypass.
module regfile_mp_rdport #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]               addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]             busy,
  input  logic [NUM_REGS-1:0]             a_hit,
  input  logic [NUM_REGS-1:0]             b_hit,
  input  logic [DATA_W-1:0]               wa_data,
  input  logic [DATA_W-1:0]               wb_data,
  output logic [DATA_W-1:0]               data,
  output logic                            busy_o
);
  // Out-of-range addresses match no register and fall through to zero.
  // Port B beats port A in the bypass, mirroring the collision rule.
  always_comb begin
    data   = '0;
    busy_o = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (addr == ADDR_W'(r)) begin
        if (BYPASS != 0 && b_hit[r])      data = wb_data;
        else if (BYPASS != 0 && a_hit[r]) data = wa_data;
        else                              data = regs[r];
        busy_o = busy[r] & ~((BYPASS != 0) & b_hit[r]);
      end
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     wr_conflict
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy_q;
  logic [NUM_REGS-1:0]             a_hit, b_hit, rsv_hit;
  logic                            conflict_q;

  // One-hot decode of each write/reserve port; r0 is excluded when hardwired
  // and out-of-range addresses decode to nothing.
  always_comb begin
    a_hit   = '0;
    b_hit   = '0;
    rsv_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ZERO_REG == 0 || r != 0) begin
        a_hit[r]   = we_a      && (wa_addr  == ADDR_W'(r));
        b_hit[r]   = we_b      && (wb_addr  == ADDR_W'(r));
        rsv_hit[r] = rsv_valid && (rsv_addr == ADDR_W'(r));
      end
    end
  end

  // Register storage; port B wins when both ports hit the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (b_hit[r])      regs[r] <= wb_data;
        else if (a_hit[r]) regs[r] <= wa_data;
      end
    end
  end

  // Scoreboard: a new reservation beats a same-cycle load return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rsv_hit[r])    busy_q[r] <= 1'b1;
        else if (b_hit[r]) busy_q[r] <= 1'b0;
      end
    end
  end

  // Collision flag, registered so it pulses the cycle after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_q <= 1'b0;
    else        conflict_q <= |(a_hit & b_hit);
  end

  assign busy        = busy_q;
  assign wr_conflict = conflict_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_rd (
      .addr   (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs   (regs),
      .busy   (busy_q),
      .a_hit  (a_hit),
      .b_hit  (b_hit),
      .wa_data(wa_data),
      .wb_data(wb_data),
      .data   (rd_data[i*DATA_W +: DATA_W]),
      .busy_o (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config (d0), a 6-register
// no-zero-reg no-bypass config (d1) and a 32-bit 16x3-port config (d2).
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // d0: defaults
  logic [5:0]  d0_rd_addr;
  logic [31:0] d0_rd_data;
  logic [1:0]  d0_rd_busy;
  logic        d0_we_a, d0_we_b, d0_rsv_valid;
  logic [2:0]  d0_wa_addr, d0_wb_addr, d0_rsv_addr;
  logic [15:0] d0_wa_data, d0_wb_data;
  logic [7:0]  d0_busy;
  logic        d0_wr_conflict;

  // d1: NUM_REGS=6, ZERO_REG=0, BYPASS=0
  logic [5:0]  d1_rd_addr;
  logic [31:0] d1_rd_data;
  logic [1:0]  d1_rd_busy;
  logic        d1_we_a, d1_we_b, d1_rsv_valid;
  logic [2:0]  d1_wa_addr, d1_wb_addr, d1_rsv_addr;
  logic [15:0] d1_wa_data, d1_wb_data;
  logic [5:0]  d1_busy;
  logic        d1_wr_conflict;

  // d2: DATA_W=32, NUM_REGS=16, ADDR_W=4, NUM_RD=3
  logic [11:0] d2_rd_addr;
  logic [95:0] d2_rd_data;
  logic [2:0]  d2_rd_busy;
  logic        d2_we_a, d2_we_b, d2_rsv_valid;
  logic [3:0]  d2_wa_addr, d2_wb_addr, d2_rsv_addr;
  logic [31:0] d2_wa_data, d2_wb_data;
  logic [15:0] d2_busy;
  logic        d2_wr_conflict;

  regfile_mp u_d0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(d0_rd_addr), .rd_data(d0_rd_data),
    .rd_busy(d0_rd_busy), .we_a(d0_we_a), .wa_addr(d0_wa_addr),
    .wa_data(d0_wa_data), .we_b(d0_we_b), .wb_addr(d0_wb_addr),
    .wb_data(d0_wb_data), .rsv_valid(d0_rsv_valid), .rsv_addr(d0_rsv_addr),
    .busy(d0_busy), .wr_conflict(d0_wr_conflict)
  );

  regfile_mp #(.NUM_REGS(6), .ZERO_REG(0), .BYPASS(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(d1_rd_addr), .rd_data(d1_rd_data),
    .rd_busy(d1_rd_busy), .we_a(d1_we_a), .wa_addr(d1_wa_addr),
    .wa_data(d1_wa_data), .we_b(d1_we_b), .wb_addr(d1_wb_addr),
    .wb_data(d1_wb_data), .rsv_valid(d1_rsv_valid), .rsv_addr(d1_rsv_addr),
    .busy(d1_busy), .wr_conflict(d1_wr_conflict)
  );

  regfile_mp #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .rd_addr(d2_rd_addr), .rd_data(d2_rd_data),
    .rd_busy(d2_rd_busy), .we_a(d2_we_a), .wa_addr(d2_wa_addr),
    .wa_data(d2_wa_data), .we_b(d2_we_b), .wb_addr(d2_wb_addr),
    .wb_data(d2_wb_data), .rsv_valid(d2_rsv_valid), .rsv_addr(d2_rsv_addr),
    .busy(d2_busy), .wr_conflict(d2_wr_conflict)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    d0_we_a = 0; d0_we_b = 0; d0_rsv_valid = 0;
    d1_we_a = 0; d1_we_b = 0; d1_rsv_valid = 0;
    d2_we_a = 0; d2_we_b = 0; d2_rsv_valid = 0;
  endtask

  function automatic logic [31:0] wexp(int k);
    if (k == 0) return 32'h0;
    return {8'hA0 + 8'(k), 8'(k), 16'hC000 | 16'(k)};
  endfunction

  task automatic test_reset;
    for (int k = 0; k < 8; k++) begin
      d0_rd_addr = {3'd0, 3'(k)};
      #1;
      checks++;
      if (d0_rd_data[15:0] !== 16'h0) begin
        errors++; $display("FAIL reset_r%0d got %h exp 0000", k, d0_rd_data[15:0]);
      end
    end
    checks++;
    if (d0_busy !== 8'h0 || d0_wr_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_state busy %h conflict %b exp 00 0", d0_busy, d0_wr_conflict);
    end
    // build up state: r3 written, r1 reserved, then a collision on r6
    d0_we_a = 1; d0_wa_addr = 3; d0_wa_data = 16'hBEEF;
    d0_rsv_valid = 1; d0_rsv_addr = 1;
    tick; idle;
    d0_we_a = 1; d0_wa_addr = 6; d0_wa_data = 16'h0001;
    d0_we_b = 1; d0_wb_addr = 6; d0_wb_data = 16'h0002;
    tick; idle;
    d0_rd_addr = {3'd0, 3'd3};
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'hBEEF || d0_busy !== 8'h02 || d0_wr_conflict !== 1'b1) begin
      errors++; $display("FAIL pre_reset data %h busy %h conflict %b exp beef 02 1",
                         d0_rd_data[15:0], d0_busy, d0_wr_conflict);
    end
    rst_n = 0;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h0 || d0_busy !== 8'h0 || d0_wr_conflict !== 1'b0) begin
      errors++; $display("FAIL async_reset data %h busy %h conflict %b exp 0000 00 0",
                         d0_rd_data[15:0], d0_busy, d0_wr_conflict);
    end
    // writes presented during reset must not land
    d0_we_a = 1; d0_wa_addr = 3; d0_wa_data = 16'hBEEF;
    d0_rsv_valid = 1; d0_rsv_addr = 3;
    tick;
    idle;
    rst_n = 1;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h0 || d0_busy !== 8'h0) begin
      errors++; $display("FAIL reset_edge_write data %h busy %h exp 0000 00", d0_rd_data[15:0], d0_busy);
    end
    tick;
  endtask

  task automatic test_zero_reg;
    d0_rd_addr = {3'd0, 3'd0};
    d1_rd_addr = {3'd0, 3'd0};
    d0_we_a = 1; d0_wa_addr = 0; d0_wa_data = 16'h1234;
    d1_we_a = 1; d1_wa_addr = 0; d1_wa_data = 16'h1234;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h0) begin
      errors++; $display("FAIL zero_same_cycle got %h exp 0000", d0_rd_data[15:0]);
    end
    checks++;
    if (d1_rd_data[15:0] !== 16'h0) begin
      errors++; $display("FAIL nozero_same_cycle got %h exp 0000", d1_rd_data[15:0]);
    end
    tick; idle;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h0) begin
      errors++; $display("FAIL zero_after got %h exp 0000", d0_rd_data[15:0]);
    end
    checks++;
    if (d1_rd_data[15:0] !== 16'h1234) begin
      errors++; $display("FAIL nozero_after got %h exp 1234", d1_rd_data[15:0]);
    end
    d0_rsv_valid = 1; d0_rsv_addr = 0;
    tick; idle;
    checks++;
    if (d0_busy !== 8'h0) begin
      errors++; $display("FAIL zero_reserve busy %h exp 00", d0_busy);
    end
  endtask

  task automatic test_bypass;
    d0_rd_addr = {3'd5, 3'd0};
    d1_rd_addr = {3'd5, 3'd0};
    d0_we_a = 1; d0_wa_addr = 5; d0_wa_data = 16'h00A5;
    d1_we_a = 1; d1_wa_addr = 5; d1_wa_data = 16'h00A5;
    #1;
    checks++;
    if (d0_rd_data[31:16] !== 16'h00A5) begin
      errors++; $display("FAIL bypass_on got %h exp 00a5", d0_rd_data[31:16]);
    end
    checks++;
    if (d1_rd_data[31:16] !== 16'h0000) begin
      errors++; $display("FAIL bypass_off got %h exp 0000", d1_rd_data[31:16]);
    end
    tick; idle;
    #1;
    checks++;
    if (d0_rd_data[31:16] !== 16'h00A5 || d1_rd_data[31:16] !== 16'h00A5) begin
      errors++; $display("FAIL bypass_after d0 %h d1 %h exp 00a5", d0_rd_data[31:16], d1_rd_data[31:16]);
    end
    // both ports writing the read address: port B is forwarded
    d0_we_a = 1; d0_wa_addr = 5; d0_wa_data = 16'hAAAA;
    d0_we_b = 1; d0_wb_addr = 5; d0_wb_data = 16'hBBBB;
    #1;
    checks++;
    if (d0_rd_data[31:16] !== 16'hBBBB) begin
      errors++; $display("FAIL bypass_prio got %h exp bbbb", d0_rd_data[31:16]);
    end
    tick; idle;
    tick;
  endtask

  task automatic test_collision;
    d0_rd_addr = {3'd0, 3'd2};
    d0_we_a = 1; d0_wa_addr = 2; d0_wa_data = 16'h1111;
    d0_we_b = 1; d0_wb_addr = 2; d0_wb_data = 16'h2222;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h2222 || d0_wr_conflict !== 1'b0) begin
      errors++; $display("FAIL coll_pre data %h conflict %b exp 2222 0", d0_rd_data[15:0], d0_wr_conflict);
    end
    tick;
    idle;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h2222 || d0_wr_conflict !== 1'b1) begin
      errors++; $display("FAIL coll_1 data %h conflict %b exp 2222 1", d0_rd_data[15:0], d0_wr_conflict);
    end
    // second collision back-to-back keeps the flag high
    d0_we_a = 1; d0_wa_addr = 2; d0_wa_data = 16'h3333;
    d0_we_b = 1; d0_wb_addr = 2; d0_wb_data = 16'h4444;
    tick; idle;
    #1;
    checks++;
    if (d0_rd_data[15:0] !== 16'h4444 || d0_wr_conflict !== 1'b1) begin
      errors++; $display("FAIL coll_2 data %h conflict %b exp 4444 1", d0_rd_data[15:0], d0_wr_conflict);
    end
    // distinct addresses are not a collision
    d0_we_a = 1; d0_wa_addr = 1; d0_wa_data = 16'h5A5A;
    d0_we_b = 1; d0_wb_addr = 2; d0_wb_data = 16'h6666;
    d0_rd_addr = {3'd2, 3'd1};
    tick; idle;
    #1;
    checks++;
    if (d0_wr_conflict !== 1'b0 || d0_rd_data !== {16'h6666, 16'h5A5A}) begin
      errors++; $display("FAIL coll_none conflict %b data %h exp 0 66665a5a", d0_wr_conflict, d0_rd_data);
    end
  endtask

  task automatic test_scoreboard;
    d0_rd_addr = {3'd3, 3'd4};
    d0_rsv_valid = 1; d0_rsv_addr = 4;
    #1;
    checks++;
    if (d0_busy !== 8'h00) begin
      errors++; $display("FAIL sb_pre busy %h exp 00", d0_busy);
    end
    tick; idle;
    #1;
    checks++;
    if (d0_busy !== 8'h10 || d0_rd_busy !== 2'b01) begin
      errors++; $display("FAIL sb_set busy %h rd_busy %b exp 10 01", d0_busy, d0_rd_busy);
    end
    tick; tick; tick;
    checks++;
    if (d0_busy !== 8'h10) begin
      errors++; $display("FAIL sb_hold busy %h exp 10", d0_busy);
    end
    d0_we_b = 1; d0_wb_addr = 4; d0_wb_data = 16'h0F0F;
    #1;
    checks++;
    if (d0_rd_busy !== 2'b00 || d0_rd_data[15:0] !== 16'h0F0F || d0_busy !== 8'h10) begin
      errors++; $display("FAIL sb_clear_comb rd_busy %b data %h busy %h exp 00 0f0f 10",
                         d0_rd_busy, d0_rd_data[15:0], d0_busy);
    end
    tick; idle;
    #1;
    checks++;
    if (d0_busy !== 8'h00 || d0_rd_data[15:0] !== 16'h0F0F) begin
      errors++; $display("FAIL sb_clear busy %h data %h exp 00 0f0f", d0_busy, d0_rd_data[15:0]);
    end
    d0_rsv_valid = 1; d0_rsv_addr = 4;
    d0_we_b = 1; d0_wb_addr = 4; d0_wb_data = 16'h5555;
    tick; idle;
    #1;
    checks++;
    if (d0_busy !== 8'h10 || d0_rd_data[15:0] !== 16'h5555) begin
      errors++; $display("FAIL sb_set_wins busy %h data %h exp 10 5555", d0_busy, d0_rd_data[15:0]);
    end
    d0_we_a = 1; d0_wa_addr = 4; d0_wa_data = 16'h7777;
    tick; idle;
    #1;
    checks++;
    if (d0_busy !== 8'h10 || d0_rd_data[15:0] !== 16'h7777) begin
      errors++; $display("FAIL sb_porta busy %h data %h exp 10 7777", d0_busy, d0_rd_data[15:0]);
    end
    d0_we_b = 1; d0_wb_addr = 4; d0_wb_data = 16'h0;
    tick; idle;
  endtask

  task automatic test_out_of_range;
    d1_rd_addr = {3'd7, 3'd6};
    d1_we_a = 1; d1_wa_addr = 6; d1_wa_data = 16'hDEAD;
    d1_we_b = 1; d1_wb_addr = 7; d1_wb_data = 16'hBEAD;
    d1_rsv_valid = 1; d1_rsv_addr = 7;
    #1;
    checks++;
    if (d1_rd_data !== 32'h0 || d1_rd_busy !== 2'b00) begin
      errors++; $display("FAIL oor_comb data %h rd_busy %b exp 0 00", d1_rd_data, d1_rd_busy);
    end
    tick; idle;
    #1;
    checks++;
    if (d1_rd_data !== 32'h0 || d1_busy !== 6'h0 || d1_rd_busy !== 2'b00) begin
      errors++; $display("FAIL oor_after data %h busy %h rd_busy %b exp 0 00 00",
                         d1_rd_data, d1_busy, d1_rd_busy);
    end
    d1_we_a = 1; d1_wa_addr = 7; d1_wa_data = 16'h1;
    d1_we_b = 1; d1_wb_addr = 7; d1_wb_data = 16'h2;
    tick; idle;
    d1_rd_addr = {3'd7, 3'd5};
    #1;
    checks++;
    if (d1_wr_conflict !== 1'b0 || d1_rd_data !== {16'h0, 16'h00A5}) begin
      errors++; $display("FAIL oor_coll conflict %b data %h exp 0 000000a5", d1_wr_conflict, d1_rd_data);
    end
  endtask

  task automatic test_wide;
    for (int k = 1; k < 16; k++) begin
      if (k % 2 == 1) begin
        d2_we_a = 1; d2_wa_addr = 4'(k); d2_wa_data = wexp(k);
      end else begin
        d2_we_b = 1; d2_wb_addr = 4'(k); d2_wb_data = wexp(k);
      end
      tick; idle;
    end
    d2_we_a = 1; d2_wa_addr = 0; d2_wa_data = 32'hFFFF_FFFF;
    tick; idle;
    for (int k = 0; k < 16; k++) begin
      int p0, p1, p2;
      p0 = k; p1 = (k + 5) % 16; p2 = (k + 11) % 16;
      d2_rd_addr = {4'(p2), 4'(p1), 4'(p0)};
      #1;
      checks++;
      if (d2_rd_data[31:0] !== wexp(p0)) begin
        errors++; $display("FAIL wide_p0_r%0d got %h exp %h", p0, d2_rd_data[31:0], wexp(p0));
      end
      checks++;
      if (d2_rd_data[63:32] !== wexp(p1)) begin
        errors++; $display("FAIL wide_p1_r%0d got %h exp %h", p1, d2_rd_data[63:32], wexp(p1));
      end
      checks++;
      if (d2_rd_data[95:64] !== wexp(p2)) begin
        errors++; $display("FAIL wide_p2_r%0d got %h exp %h", p2, d2_rd_data[95:64], wexp(p2));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    d0_rd_addr = '0; d0_wa_addr = '0; d0_wb_addr = '0; d0_rsv_addr = '0;
    d0_wa_data = '0; d0_wb_data = '0;
    d1_rd_addr = '0; d1_wa_addr = '0; d1_wb_addr = '0; d1_rsv_addr = '0;
    d1_wa_data = '0; d1_wb_data = '0;
    d2_rd_addr = '0; d2_wa_addr = '0; d2_wb_addr = '0; d2_rsv_addr = '0;
    d2_wa_data = '0; d2_wb_data = '0;
    idle;
    #12 rst_n = 1;
    tick;
    test_reset;
    test_zero_reg;
    test_bypass;
    test_collision;
    test_scoreboard;
    test_out_of_range;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the RISC-16 datapath. It replaces the fixed 8×16 two-read register file with configurable width, depth and read-port count. It adds a second write port for memory writeback, same-cycle write-to-read bypass, and a per-register load scoreboard. It sits between decode (read addresses from rA/rB/rC) and the writeback stage (ALU/PC result on port A, load data on port B).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of architectural registers (2..64)
- ADDR_W, 3, register address width; must satisfy 2^ADDR_W ≥ NUM_REGS
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero
- BYPASS, 1, when 1 same-cycle writes are forwarded to read ports

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  register addressed by port i has a load outstanding
- we_a  in  1  write enable, port A (ALU/PC writeback)
- wa_addr  in  ADDR_W  port A write address
- wa_data  in  DATA_W  port A write data
- we_b  in  1  write enable, port B (memory writeback)
- wb_addr  in  ADDR_W  port B write address
- wb_data  in  DATA_W  port B write data
- rsv_valid  in  1  reserve: mark rsv_addr as pending a load
- rsv_addr  in  ADDR_W  register to reserve
- busy  out  NUM_REGS  scoreboard vector, bit r = register r pending
- wr_conflict  out  1  registered one-cycle pulse, A and B wrote the same register

## Operation
- Storage: NUM_REGS × DATA_W flops. Each write port updates its register on the rising edge when its enable is high.
- Zero register (ZERO_REG=1): writes to address 0 are dropped, reads return 0, reservations of 0 are dropped, busy[0] is always 0.
- Out-of-range address (≥ NUM_REGS): reads return 0, rd_busy is 0, writes and reservations are ignored.
- Write collision (we_a & we_b, same valid, non-zero address): port B data is stored and wr_conflict pulses high the next cycle. Port A is discarded.
- Reads are combinational.
  - With BYPASS=1, rd_data returns, in priority order: port B data if writing the same address this cycle, else port A data if writing it, else stored value.
  - With BYPASS=0, rd_data returns the stored value only.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the next edge.
  - A port B write clears busy[wb_addr].
  - Set and clear of the same register in one cycle: set wins, because a new load is issued.
  - Port A writes never change busy.
- rd_busy[i] = busy[rd_addr[i]]. With BYPASS=1 it is also forced to 0 when port B writes that address in the same cycle.

## Timing
- Reset, asynchronous and immediate: all registers 0, busy all 0, wr_conflict 0. Therefore rd_data is 0 for every address.
- Reset deassertion: first capturing edge is the first rising clk with rst_n high.
- Write-to-read latency:
  - BYPASS=1: 0 cycles, data visible in the cycle of the write.
  - BYPASS=0: 1 cycle, visible after the edge.
- Reserve-to-busy latency: 1 cycle. Port B clear: 0 cycles on rd_busy with BYPASS=1, 1 cycle on busy.
- wr_conflict: asserted exactly one cycle after the colliding edge. Back-to-back collisions hold it high.
- Reset mid-operation: in-flight writes and reservations are lost, and no write occurs on the reset edge.

## Test plan
- Reset check: write 16'hBEEF to r3, then pulse rst_n low asynchronously mid-cycle -> r3 reads 16'h0000 immediately; busy is 0 and wr_conflict is 0.
- Zero register: we_a=1, wa_addr=0, wa_data=16'h1234 -> port 0 reading r0 returns 16'h0000 in the same cycle and thereafter. Repeat with ZERO_REG=0 -> returns 16'h1234 after the edge.
- Bypass: we_a writes 16'h00A5 to r5 while rd_addr port 1 = 5 -> rd_data port 1 = 16'h00A5 in the same cycle with BYPASS=1. With BYPASS=0 the old value is returned until the next edge.
- Collision: we_a (r2, 16'h1111) and we_b (r2, 16'h2222) on the same edge -> r2 = 16'h2222 and a one-cycle wr_conflict pulse.
- Scoreboard: rsv_valid on r4 -> busy[4]=1 next cycle. Three idle cycles later, we_b writes r4 = 16'h0F0F -> rd_busy=0 and data 16'h0F0F in the same cycle, and busy[4]=0 after the edge. Then rsv r4 and we_b r4 in the same cycle -> busy[4] stays 1.
- Generalisation: DATA_W=32, NUM_REGS=16, ADDR_W=4, NUM_RD=3 -> write distinct values to r1..r15, read all three ports concurrently and match every value. Address 15 wraps nothing, and ports are independent.
